// File: rtl/dsp48_pkg.sv
// Shared widths and opmode encodings for the DSP48A1-style slice stages.
package dsp48_pkg;
   localparam int DAB_W = 48;
   localparam int M_W   = 36;
   localparam int P_W   = 48;

   typedef enum logic [1:0] {
      X_ZERO = 2'd0,
      X_M    = 2'd1,
      X_P    = 2'd2,
      X_DAB  = 2'd3
   } x_sel_e;

   typedef enum logic [1:0] {
      Z_ZERO = 2'd0,
      Z_PCIN = 2'd1,
      Z_P    = 2'd2,
      Z_C    = 2'd3
   } z_sel_e;

   localparam logic OP_ADD = 1'b0;
   localparam logic OP_SUB = 1'b1;
endpackage

// File: rtl/dsp_pipe_reg.sv
// Optional pipeline register: CE, synchronous clear (priority over CE), async active-low reset.
// With REG=0 the register is bypassed and its control inputs have no effect.
module dsp_pipe_reg #(
   parameter int REG   = 1,
   parameter int WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ce_i,
   input  logic             clr_i,
   input  logic [WIDTH-1:0] d_i,
   output logic [WIDTH-1:0] q_o
);
   generate
      if (REG != 0) begin : g_reg
         logic [WIDTH-1:0] data_q;
         logic [WIDTH-1:0] data_d;

         always_comb begin
            data_d = data_q;
            if (clr_i)
               data_d = '0;
            else if (ce_i)
               data_d = d_i;
         end

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n)
               data_q <= '0;
            else
               data_q <= data_d;
         end

         assign q_o = data_q;
      end else begin : g_bypass
         logic unused_ctrl;
         assign unused_ctrl = ^{clk, rst_n, ce_i, clr_i};
         assign q_o         = d_i;
      end
   endgenerate
endmodule

// File: rtl/dsp_post_adder_stage.sv
// Post-adder stage: X/Z operand muxes, add/subtract with carry-in, optional P/carry/opmode registers.
// Optional macro DSP_P_ZERO_DETECT_EN adds a registered P_ZERO flag.
module dsp_post_adder_stage
   import dsp48_pkg::*;
#(
   parameter int PREG        = 1,
   parameter int CARRYOUTREG = 1,
   parameter int OPMODE_REG  = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [DAB_W-1:0] DAB,
   input  logic [M_W-1:0]   m_reg,
   input  logic [P_W-1:0]   c_reg,
   input  logic [P_W-1:0]   pcin,
   input  logic [1:0]       opmode10,
   input  logic [1:0]       opmode32,
   input  logic             opmode7,
   input  logic             cin,
   input  logic             CEOPMODE,
   input  logic             CEP,
   input  logic             CECARRYIN,
   input  logic             RSTOPMODE,
   input  logic             RSTP,
   input  logic             RSTCARRYIN,
   output logic [M_W-1:0]   M,
   output logic [P_W-1:0]   P,
   output logic [P_W-1:0]   PCOUT,
   output logic             CARRYOUT,
`ifdef DSP_P_ZERO_DETECT_EN
   output logic             P_ZERO,
`endif
   output logic             CARRYOUTF
);
   logic [1:0]     opmode10_q;
   logic [1:0]     opmode32_q;
   logic           opmode7_q;
   logic [P_W-1:0] x_mux;
   logic [P_W-1:0] z_mux;
   logic [P_W:0]   post_sum;
   logic [P_W-1:0] p_q;
   logic           carry_q;

   dsp_pipe_reg #(.REG(OPMODE_REG), .WIDTH(2)) u_opmode10_reg (
      .clk(clk), .rst_n(rst_n), .ce_i(CEOPMODE), .clr_i(RSTOPMODE),
      .d_i(opmode10), .q_o(opmode10_q)
   );

   dsp_pipe_reg #(.REG(OPMODE_REG), .WIDTH(2)) u_opmode32_reg (
      .clk(clk), .rst_n(rst_n), .ce_i(CEOPMODE), .clr_i(RSTOPMODE),
      .d_i(opmode32), .q_o(opmode32_q)
   );

   dsp_pipe_reg #(.REG(OPMODE_REG), .WIDTH(1)) u_opmode7_reg (
      .clk(clk), .rst_n(rst_n), .ce_i(CEOPMODE), .clr_i(RSTOPMODE),
      .d_i(opmode7), .q_o(opmode7_q)
   );

   // P feedback taps the stage output, so with PREG=0 the X/Z=P selections form a loop.
   always_comb begin
      x_mux = '0;
      case (opmode10_q)
         X_ZERO:  x_mux = '0;
         X_M:     x_mux = {{(P_W-M_W){1'b0}}, m_reg};
         X_P:     x_mux = p_q;
         X_DAB:   x_mux = DAB;
         default: x_mux = '0;
      endcase
   end

   always_comb begin
      z_mux = '0;
      case (opmode32_q)
         Z_ZERO:  z_mux = '0;
         Z_PCIN:  z_mux = pcin;
         Z_P:     z_mux = p_q;
         Z_C:     z_mux = c_reg;
         default: z_mux = '0;
      endcase
   end

   // Bit P_W is the carry when adding and the borrow when subtracting.
   always_comb begin
      if (opmode7_q == OP_SUB)
         post_sum = {1'b0, z_mux} - ({1'b0, x_mux} + {{P_W{1'b0}}, cin});
      else
         post_sum = {1'b0, z_mux} + {1'b0, x_mux} + {{P_W{1'b0}}, cin};
   end

   dsp_pipe_reg #(.REG(PREG), .WIDTH(P_W)) u_p_reg (
      .clk(clk), .rst_n(rst_n), .ce_i(CEP), .clr_i(RSTP),
      .d_i(post_sum[P_W-1:0]), .q_o(p_q)
   );

   dsp_pipe_reg #(.REG(CARRYOUTREG), .WIDTH(1)) u_carry_reg (
      .clk(clk), .rst_n(rst_n), .ce_i(CECARRYIN), .clr_i(RSTCARRYIN),
      .d_i(post_sum[P_W]), .q_o(carry_q)
   );

`ifdef DSP_P_ZERO_DETECT_EN
   logic p_zero_d;
   assign p_zero_d = (post_sum[P_W-1:0] == '0);

   dsp_pipe_reg #(.REG(PREG), .WIDTH(1)) u_p_zero_reg (
      .clk(clk), .rst_n(rst_n), .ce_i(CEP), .clr_i(RSTP),
      .d_i(p_zero_d), .q_o(P_ZERO)
   );
`endif

   assign M         = m_reg;
   assign P         = p_q;
   assign PCOUT     = p_q;
   assign CARRYOUT  = carry_q;
   assign CARRYOUTF = carry_q;
endmodule

// File: tb/tb_dsp_post_adder_stage.sv
// Randomized and directed bench for dsp_post_adder_stage against an arithmetic reference model.
module tb_dsp_post_adder_stage;
   localparam longint TWO48 = 64'h0001_0000_0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [47:0] DAB;
   logic [35:0] m_reg;
   logic [47:0] c_reg;
   logic [47:0] pcin;
   logic [1:0]  opmode10;
   logic [1:0]  opmode32;
   logic        opmode7;
   logic        cin;
   logic        CEOPMODE, CEP, CECARRYIN;
   logic        RSTOPMODE, RSTP, RSTCARRYIN;
   logic [35:0] M;
   logic [47:0] P;
   logic [47:0] PCOUT;
   logic        CARRYOUT;
   logic        CARRYOUTF;
`ifdef DSP_P_ZERO_DETECT_EN
   logic        P_ZERO;
`endif

   int n_vec = 0;
   int n_err = 0;

   // Reference state: what P, carry and the latched opmode should be after the last edge.
   logic [47:0] exp_p;
   logic        exp_co;
   logic [1:0]  mdl_x;
   logic [1:0]  mdl_z;
   logic        mdl_sub;

   always #5 clk = ~clk;

   dsp_post_adder_stage dut (
      .clk(clk), .rst_n(rst_n), .DAB(DAB), .m_reg(m_reg), .c_reg(c_reg), .pcin(pcin),
      .opmode10(opmode10), .opmode32(opmode32), .opmode7(opmode7), .cin(cin),
      .CEOPMODE(CEOPMODE), .CEP(CEP), .CECARRYIN(CECARRYIN),
      .RSTOPMODE(RSTOPMODE), .RSTP(RSTP), .RSTCARRYIN(RSTCARRYIN),
      .M(M), .P(P), .PCOUT(PCOUT), .CARRYOUT(CARRYOUT),
`ifdef DSP_P_ZERO_DETECT_EN
      .P_ZERO(P_ZERO),
`endif
      .CARRYOUTF(CARRYOUTF)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] want);
      n_vec++;
      if (obs !== want) begin
         n_err++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, want);
      end
   endtask

   // One clock edge: predict from the latched mode and current inputs, then compare all outputs.
   task automatic step();
      longint x, z, r;
      logic [47:0] np;
      logic        nco;
      case (mdl_x)
         2'd0: x = 0;
         2'd1: x = longint'(m_reg);
         2'd2: x = longint'(exp_p);
         default: x = longint'(DAB);
      endcase
      case (mdl_z)
         2'd0: z = 0;
         2'd1: z = longint'(pcin);
         2'd2: z = longint'(exp_p);
         default: z = longint'(c_reg);
      endcase
      if (mdl_sub) begin
         r   = z - (x + longint'(cin));
         nco = (r < 0);
         if (r < 0) r = r + TWO48;
      end else begin
         r   = z + x + longint'(cin);
         nco = (r >= TWO48);
         if (r >= TWO48) r = r - TWO48;
      end
      np = r[47:0];
      @(posedge clk);
      #1;
      if (RSTP) exp_p = '0;
      else if (CEP) exp_p = np;
      if (RSTCARRYIN) exp_co = 1'b0;
      else if (CECARRYIN) exp_co = nco;
      if (RSTOPMODE) begin
         mdl_x = 2'd0; mdl_z = 2'd0; mdl_sub = 1'b0;
      end else if (CEOPMODE) begin
         mdl_x = opmode10; mdl_z = opmode32; mdl_sub = opmode7;
      end
      check("P", 64'(P), 64'(exp_p));
      check("CARRYOUT", 64'(CARRYOUT), 64'(exp_co));
      check("PCOUT", 64'(PCOUT), 64'(exp_p));
      check("CARRYOUTF", 64'(CARRYOUTF), 64'(exp_co));
      check("M", 64'(M), 64'(m_reg));
      $display("step om=%0d/%0d/%0d P=%h CO=%0b", opmode10, opmode32, opmode7, P, CARRYOUT);
   endtask

   initial begin
      rst_n = 1'b0;
      DAB = '0; m_reg = '0; c_reg = '0; pcin = '0;
      opmode10 = 2'd0; opmode32 = 2'd0; opmode7 = 1'b0; cin = 1'b0;
      CEOPMODE = 1'b1; CEP = 1'b1; CECARRYIN = 1'b1;
      RSTOPMODE = 1'b0; RSTP = 1'b0; RSTCARRYIN = 1'b0;
      exp_p = '0; exp_co = 1'b0; mdl_x = 2'd0; mdl_z = 2'd0; mdl_sub = 1'b0;
      #12;
      check("reset_P", 64'(P), 64'h0);
      check("reset_CARRYOUT", 64'(CARRYOUT), 64'h0);
      rst_n = 1'b1;

      // Add with carry-in
      opmode10 = 2'd3; opmode32 = 2'd3; opmode7 = 1'b0;
      DAB = 48'h1; c_reg = 48'h2; cin = 1'b1;
      step(); step();
      check("add_P", 64'(P), 64'h4);
      check("add_CO", 64'(CARRYOUT), 64'h0);

      // Overflow wraps and sets carry
      DAB = 48'hFFFF_FFFF_FFFF; c_reg = 48'hFFFF_FFFF_FFFF; cin = 1'b0;
      step();
      check("ovf_P", 64'(P), 64'hFFFF_FFFF_FFFE);
      check("ovf_CO", 64'(CARRYOUT), 64'h1);

      // Subtract pcin - (M + cin)
      opmode10 = 2'd1; opmode32 = 2'd1; opmode7 = 1'b1;
      pcin = 48'd100; m_reg = 36'd30; cin = 1'b1;
      step(); step();
      check("sub_P", 64'(P), 64'd69);
      check("sub_CO", 64'(CARRYOUT), 64'h0);
      pcin = 48'd0; m_reg = 36'd1; cin = 1'b0;
      step();
      check("borrow_P", 64'(P), 64'hFFFF_FFFF_FFFF);
      check("borrow_CO", 64'(CARRYOUT), 64'h1);

      // Accumulate M into P starting from a cleared P
      opmode10 = 2'd1; opmode32 = 2'd2; opmode7 = 1'b0; m_reg = 36'd5; cin = 1'b0;
      RSTP = 1'b1;
      step();
      check("acc_clr", 64'(P), 64'h0);
      RSTP = 1'b0;
      for (int i = 1; i <= 4; i++) begin
         step();
         check("acc_P", 64'(P), 64'(5 * i));
      end
      CEP = 1'b0;
      step();
      check("acc_hold", 64'(P), 64'd20);
      RSTP = 1'b1;
      step();
      check("acc_rstp", 64'(P), 64'h0);
      RSTP = 1'b0; CEP = 1'b1;

      // Random opmode and data
      for (int i = 0; i < 100; i++) begin
         opmode10 = 2'($urandom_range(0, 3));
         opmode32 = 2'($urandom_range(0, 3));
         opmode7  = 1'($urandom_range(0, 1));
         cin      = 1'($urandom_range(0, 1));
         DAB      = {16'($urandom), 32'($urandom)};
         c_reg    = {16'($urandom), 32'($urandom)};
         pcin     = {16'($urandom), 32'($urandom)};
         m_reg    = {4'($urandom), 32'($urandom)};
         step();
      end

      // Force a nonzero P, then async reset between edges must clear it immediately
      opmode10 = 2'd3; opmode32 = 2'd0; opmode7 = 1'b0;
      DAB = 48'h1234_5678_9ABC; cin = 1'b0;
      step(); step();
      check("pre_rst_P", 64'(P), 64'h1234_5678_9ABC);
      #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_P", 64'(P), 64'h0);
      check("async_rst_CO", 64'(CARRYOUT), 64'h0);
      check("async_rst_PCOUT", 64'(PCOUT), 64'h0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
